i2s_rx: RTL and testbench



---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_rx_sync.sv | 41 ++++
 rtl/i2s_rx.sv | 170 +++++++++++++++++
 tb/tb_i2s_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM state encoding,
// bit-counter width and the lrck-stuck resync timeout.
package i2s_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int                  BITCNT_W     = 5;
  localparam logic [BITCNT_W-1:0] BITCNT_MAX   = '1;
  localparam int                  RESYNC_TICKS = 64;

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchroniser for bck/lrck/data with a bck rising-edge pulse.
// All three lines are tapped from the same stage so they stay mutually aligned.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic bck,
  input  logic lrck,
  input  logic data,
  output logic lrck_s,
  output logic data_s,
  output logic bck_rise
);

  logic [SYNC_STAGES-1:0] bck_q;
  logic [SYNC_STAGES-1:0] lrck_q;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   bck_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bck_q    <= '0;
      lrck_q   <= '0;
      data_q   <= '0;
      bck_prev <= 1'b0;
    end else begin
      bck_q    <= {bck_q[SYNC_STAGES-2:0], bck};
      lrck_q   <= {lrck_q[SYNC_STAGES-2:0], lrck};
      data_q   <= {data_q[SYNC_STAGES-2:0], data};
      bck_prev <= bck_q[SYNC_STAGES-1];
    end
  end

  assign lrck_s   = lrck_q[SYNC_STAGES-1];
  assign data_s   = data_q[SYNC_STAGES-1];
  assign bck_rise = bck_q[SYNC_STAGES-1] & ~bck_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCK/LRCK/DATA in clk_sys, deserialises L/R words
// and presents stereo pairs on a valid/ready interface with sticky overrun.
// Optional left-justified timing via `define I2S_RX_LEFT_JUSTIFIED_EN (adds fmt_lj).
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             i2s_bck,
  input  logic             i2s_lrck,
  input  logic             i2s_data,
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  input  logic             fmt_lj,
`endif
  input  logic             sample_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] sample_l,
  output logic [WIDTH-1:0] sample_r,
  output logic             sample_valid,
  output logic             overrun,
  output logic             locked
);

  localparam logic [BITCNT_W-1:0] WIDTH_C  = BITCNT_W'(WIDTH);
  localparam logic [6:0]          RESYNC_C = 7'(RESYNC_TICKS);

  logic lj;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  assign lj = fmt_lj;
`else
  assign lj = 1'b0;
`endif

  logic lrck_s, data_s, tick;

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .bck      (i2s_bck),
    .lrck     (i2s_lrck),
    .data     (i2s_data),
    .lrck_s   (lrck_s),
    .data_s   (data_s),
    .bck_rise (tick)
  );

  state_t              state;
  logic                channel;
  logic                lrck_prev;
  logic [WIDTH-1:0]    shreg;
  logic [BITCNT_W-1:0] bitcnt;
  logic [6:0]          stable_cnt;
  logic [WIDTH-1:0]    left_hold;
  logic                left_valid;

  logic                lrck_chg, word_done, new_pair, timeout;
  logic [WIDTH-1:0]    fin_sh, word;
  logic [BITCNT_W-1:0] fin_cnt, shamt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lrck_chg = lrck_s ^ lrck_prev;
    fin_sh   = shreg;
    fin_cnt  = bitcnt;
    // In I2S the tick on which lrck flips still carries the finishing word's LSB.
    if (!lj && bitcnt < WIDTH_C) begin
      fin_sh  = {shreg[WIDTH-2:0], data_s};
      fin_cnt = bitcnt + 1'b1;
    end
    shamt     = (fin_cnt >= WIDTH_C) ? '0 : WIDTH_C - fin_cnt;
    word      = fin_sh << shamt;
    word_done = tick && (state == SHIFT) && lrck_chg;
    new_pair  = word_done && channel && left_valid;
    timeout   = tick && (state == SHIFT) && !lrck_chg &&
                (stable_cnt == RESYNC_C) && (bitcnt == BITCNT_MAX);
  end

  // NOTE: the holding registers are a handful of flops, not a RAM, so they are
  // reset with everything else and a partial word can never leak out.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      channel    <= 1'b0;
      lrck_prev  <= 1'b0;
      shreg      <= '0;
      bitcnt     <= '0;
      stable_cnt <= '0;
      left_hold  <= '0;
      left_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      if (tick) begin
        lrck_prev  <= lrck_s;
        stable_cnt <= lrck_chg ? '0 :
                      (stable_cnt == RESYNC_C) ? stable_cnt : stable_cnt + 1'b1;
      end
      case (state)
        HUNT: begin
          if (tick && lrck_chg) begin
            channel <= lrck_s;
            if (lj) begin
              shreg  <= {{(WIDTH-1){1'b0}}, data_s};
              bitcnt <= 5'd1;
              state  <= SHIFT;
            end else begin
              state  <= DELAY;
            end
          end
        end
        // The delay slot was the lrck-change tick itself; DELAY only clears.
        DELAY: begin
          shreg  <= '0;
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (timeout) begin
            state      <= HUNT;
            locked     <= 1'b0;
            left_valid <= 1'b0;
          end else if (word_done) begin
            if (!channel) begin
              left_hold  <= word;
              left_valid <= 1'b1;
              locked     <= 1'b1;
            end else begin
              left_valid <= 1'b0;
            end
            channel <= lrck_s;
            if (lj) begin
              shreg  <= {{(WIDTH-1){1'b0}}, data_s};
              bitcnt <= 5'd1;
            end else begin
              shreg  <= '0;
              bitcnt <= '0;
            end
          end else if (tick) begin
            if (bitcnt < WIDTH_C) shreg <= {shreg[WIDTH-2:0], data_s};
            if (bitcnt != BITCNT_MAX) bitcnt <= bitcnt + 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // Output stage: a waiting pair is never overwritten; a drop sets overrun.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (new_pair && (!sample_valid || sample_ready)) begin
        sample_l     <= left_hold;
        sample_r     <= word;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (new_pair && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (overrun_clr)                          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives BCK at clk_sys/8 and checks decoded pairs,
// truncation/padding, overrun handling and lrck-stuck resync.
module tb_i2s_rx;

  localparam int WIDTH = 16;

  logic             clk_sys      = 1'b0;
  logic             reset_n      = 1'b0;
  logic             i2s_bck      = 1'b0;
  logic             i2s_lrck     = 1'b0;
  logic             i2s_data     = 1'b0;
  logic             sample_ready = 1'b0;
  logic             overrun_clr  = 1'b0;
  logic [WIDTH-1:0] sample_l, sample_r;
  logic             sample_valid, overrun, locked;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  logic             fmt_lj       = 1'b0;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_xfer  = 0;
  int          x0;
  logic [15:0] cap_l   = '0;
  logic [15:0] cap_r   = '0;
  logic        carry   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  i2s_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i2s_bck      (i2s_bck),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    .fmt_lj       (fmt_lj),
`endif
    .sample_ready (sample_ready),
    .overrun_clr  (overrun_clr),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .locked       (locked)
  );

  // Record every accepted pair, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (sample_valid && sample_ready) begin
      n_xfer++;
      cap_l = sample_l;
      cap_r = sample_r;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One BCK period (8 clk_sys): low half with new lrck/data, then high half.
  // With rdy_pulse, sample_ready is high for exactly the cycle in which the
  // receiver sees this rising edge (two sync flops plus edge detect).
  task automatic bit_tick(input logic lr, input logic d, input logic rdy_pulse);
    @(posedge clk_sys); #1;
    i2s_bck = 1'b0; i2s_lrck = lr; i2s_data = d;
    repeat (4) @(posedge clk_sys); #1;
    i2s_bck = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    if (rdy_pulse) sample_ready = 1'b1;
    @(posedge clk_sys); #1;
    if (rdy_pulse) sample_ready = 1'b0;
  endtask

  // One lrck slot of wl bits. I2S: first bit is the previous word's LSB.
  task automatic send_slot(input logic lr, input logic [23:0] val, input int wl,
                           input logic lj, input logic rdy0);
    for (int i = 0; i < wl; i++) begin
      logic d;
      d = lj ? val[wl-1-i] : ((i == 0) ? carry : val[wl-i]);
      bit_tick(lr, d, rdy0 && (i == 0));
    end
    carry = val[0];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0; carry = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_sys); #1;
    check("rst_valid",   32'(sample_valid), 32'h0);
    check("rst_overrun", 32'(overrun),      32'h0);
    check("rst_locked",  32'(locked),       32'h0);
    check("rst_l",       32'(sample_l),     32'h0);
    check("rst_r",       32'(sample_r),     32'h0);

    // Basic 16-bit frame
    do_reset();
    sample_ready = 1'b1;
    x0 = n_xfer;
    send_slot(1'b1, 24'h0000, 16, 1'b0, 1'b0);
    send_slot(1'b0, 24'h8001, 16, 1'b0, 1'b0);
    check("basic_unlocked", 32'(locked), 32'h0);
    send_slot(1'b1, 24'h7FFE, 16, 1'b0, 1'b0);
    check("basic_locked", 32'(locked), 32'h1);
    check("basic_no_early", 32'(n_xfer - x0), 32'h0);
    send_slot(1'b0, 24'h0000, 16, 1'b0, 1'b0);
    check("basic_xfers", 32'(n_xfer - x0), 32'h1);
    check("basic_l", 32'(cap_l), 32'h8001);
    check("basic_r", 32'(cap_r), 32'h7FFE);
    check("basic_valid_drop", 32'(sample_valid), 32'h0);

    // 24-bit words truncated to 16
    do_reset();
    x0 = n_xfer;
    send_slot(1'b1, 24'h000000, 24, 1'b0, 1'b0);
    send_slot(1'b0, 24'hABCDEF, 24, 1'b0, 1'b0);
    send_slot(1'b1, 24'h123456, 24, 1'b0, 1'b0);
    send_slot(1'b0, 24'h000000, 24, 1'b0, 1'b0);
    check("trunc_xfers", 32'(n_xfer - x0), 32'h1);
    check("trunc_l", 32'(cap_l), 32'hABCD);
    check("trunc_r", 32'(cap_r), 32'h1234);

    // 8-bit words zero-padded
    do_reset();
    x0 = n_xfer;
    send_slot(1'b1, 24'h00, 8, 1'b0, 1'b0);
    send_slot(1'b0, 24'h5A, 8, 1'b0, 1'b0);
    send_slot(1'b1, 24'hA5, 8, 1'b0, 1'b0);
    send_slot(1'b0, 24'h00, 8, 1'b0, 1'b0);
    check("pad_xfers", 32'(n_xfer - x0), 32'h1);
    check("pad_l", 32'(cap_l), 32'h5A00);
    check("pad_r", 32'(cap_r), 32'hA500);

    // Overrun: ready held low across three pairs
    do_reset();
    sample_ready = 1'b0;
    x0 = n_xfer;
    send_slot(1'b1, 24'h0000, 16, 1'b0, 1'b0);
    send_slot(1'b0, 24'h1111, 16, 1'b0, 1'b0);
    send_slot(1'b1, 24'h2222, 16, 1'b0, 1'b0);
    send_slot(1'b0, 24'h3333, 16, 1'b0, 1'b0);
    check("ovr_first_valid", 32'(sample_valid), 32'h1);
    check("ovr_first_clean", 32'(overrun), 32'h0);
    send_slot(1'b1, 24'h4444, 16, 1'b0, 1'b0);
    send_slot(1'b0, 24'h5555, 16, 1'b0, 1'b0);
    send_slot(1'b1, 24'h6666, 16, 1'b0, 1'b0);
    send_slot(1'b0, 24'h7777, 16, 1'b0, 1'b0);
    check("ovr_valid", 32'(sample_valid), 32'h1);
    check("ovr_keep_l", 32'(sample_l), 32'h1111);
    check("ovr_keep_r", 32'(sample_r), 32'h2222);
    check("ovr_set", 32'(overrun), 32'h1);
    @(posedge clk_sys); #1 overrun_clr = 1'b1;
    @(posedge clk_sys); #1 overrun_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'h0);
    send_slot(1'b1, 24'h8888, 16, 1'b0, 1'b0);
    send_slot(1'b0, 24'h0000, 16, 1'b0, 1'b1);
    check("coinc_xfers", 32'(n_xfer - x0), 32'h1);
    check("coinc_old_l", 32'(cap_l), 32'h1111);
    check("coinc_old_r", 32'(cap_r), 32'h2222);
    check("coinc_valid", 32'(sample_valid), 32'h1);
    check("coinc_new_l", 32'(sample_l), 32'h7777);
    check("coinc_new_r", 32'(sample_r), 32'h8888);
    check("coinc_no_ovr", 32'(overrun), 32'h0);

    // Mid-slot start, then lrck stuck -> resync and realign
    do_reset();
    sample_ready = 1'b1;
    x0 = n_xfer;
    send_slot(1'b1, 24'h0015, 5, 1'b0, 1'b0);
    send_slot(1'b0, 24'hAAAA, 16, 1'b0, 1'b0);
    check("mid_no_pair", 32'(n_xfer - x0), 32'h0);
    check("mid_unlocked", 32'(locked), 32'h0);
    send_slot(1'b1, 24'h5555, 16, 1'b0, 1'b0);
    check("mid_locked", 32'(locked), 32'h1);
    for (int i = 0; i < 80; i++) bit_tick(1'b1, 1'b1, 1'b0);
    check("stuck_unlocked", 32'(locked), 32'h0);
    check("stuck_no_pair", 32'(n_xfer - x0), 32'h0);
    check("stuck_no_valid", 32'(sample_valid), 32'h0);
    send_slot(1'b0, 24'h1357, 16, 1'b0, 1'b0);
    send_slot(1'b1, 24'h2468, 16, 1'b0, 1'b0);
    check("resync_locked", 32'(locked), 32'h1);
    send_slot(1'b0, 24'h0000, 16, 1'b0, 1'b0);
    check("resync_xfers", 32'(n_xfer - x0), 32'h1);
    check("resync_l", 32'(cap_l), 32'h1357);
    check("resync_r", 32'(cap_r), 32'h2468);

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    // Left-justified: no delay bit
    fmt_lj = 1'b1;
    do_reset();
    x0 = n_xfer;
    send_slot(1'b1, 24'h0000, 16, 1'b1, 1'b0);
    send_slot(1'b0, 24'h1234, 16, 1'b1, 1'b0);
    send_slot(1'b1, 24'h5678, 16, 1'b1, 1'b0);
    send_slot(1'b0, 24'h0000, 16, 1'b1, 1'b0);
    check("lj_xfers", 32'(n_xfer - x0), 32'h1);
    check("lj_l", 32'(cap_l), 32'h1234);
    check("lj_r", 32'(cap_r), 32'h5678);
    fmt_lj = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
